// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache: same-cycle hits, multi-beat
// sequential line refill over valid/ready, fence.i flush of all lines.
module inst_cache_dm #(
  parameter int ADDR_WIDTH = 17,
  parameter int INST_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 32,
  parameter bit BYTE_SWAP  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  pc_cache_stall,
  input  logic                  flush,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  cache_enable,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [INST_WIDTH-1:0] mem_data
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    COMMIT
  } state_e;

  state_e                  state_q, state_d;
  logic [OFF_W-1:0]        beat_q, beat_d;
  logic [TAG_W-1:0]        line_tag_q, line_tag_d;
  logic [IDX_W-1:0]        line_idx_q, line_idx_d;
  logic                    flush_pend_q, flush_pend_d;
  logic [NUM_LINES-1:0]    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;

  logic [INST_WIDTH-1:0]   data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]        tags_q [NUM_LINES];

  logic [OFF_W-1:0]        offset;
  logic [IDX_W-1:0]        index;
  logic [TAG_W-1:0]        tag;
  logic [OFF_W-1:0]        beat_inc;
  logic                    hit;
  logic                    beat_we;
  logic                    tag_we;
  logic [INST_WIDTH-1:0]   word;
  logic [INST_WIDTH-1:0]   word_out;

  assign offset   = addr[OFF_W+1:2];
  assign index    = addr[OFF_W+IDX_W+1:OFF_W+2];
  assign tag      = addr[ADDR_WIDTH-1:OFF_W+IDX_W+2];
  assign beat_inc = beat_q + 1'b1;

  assign hit = ce && valid_q[index]
            && (tags_q[index] == tag)
            && (state_q == IDLE);

  assign word = data_q[index][offset];

  generate
    if (BYTE_SWAP) begin : g_swap
      assign word_out = {word[7:0], word[15:8],
                         word[23:16], word[31:24]};
    end else begin : g_pass
      assign word_out = word;
    end
  endgenerate

  assign cache_enable = hit && !pc_cache_stall;
  assign inst         = cache_enable ? word_out : '0;
  assign mem_req      = (state_q == REFILL);
  assign mem_addr     = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    line_tag_d   = line_tag_q;
    line_idx_d   = line_idx_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    mem_addr_d   = mem_addr_q;
    beat_we      = 1'b0;
    tag_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce && !hit && !flush) begin
          state_d      = REFILL;
          line_tag_d   = tag;
          line_idx_d   = index;
          beat_d       = '0;
          flush_pend_d = 1'b0;
          mem_addr_d   = {tag, index, {OFF_W{1'b0}}, 2'b00};
        end
      end
      REFILL: begin
        if (mem_ready) begin
          beat_we    = 1'b1;
          beat_d     = beat_inc;
          mem_addr_d = {line_tag_q, line_idx_q, beat_inc, 2'b00};
          if (beat_q == LAST_BEAT) state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (!flush_pend_q) begin
          tag_we              = 1'b1;
          valid_d[line_idx_q] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush wins over a same-edge commit
    if (flush) begin
      valid_d = '0;
      if (state_q != IDLE) flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      line_tag_q   <= '0;
      line_idx_q   <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      line_tag_q   <= line_tag_d;
      line_idx_q   <= line_idx_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_we) data_q[line_idx_q][beat_q] <= mem_data;
    if (tag_we) tags_q[line_idx_q] <= line_tag_q;
  end

endmodule
